// File: rtl/rx_phy_pkg.sv
// Shared definitions for the serial receive path: comma symbol, lane count,
// and the alignment FSM state encoding (also exported as a debug port).
package rx_phy_pkg;

  localparam logic [7:0] COMMA_SYM = 8'hBC;
  localparam int         NUM_LANES = 4;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } sync_state_e;

endpackage : rx_phy_pkg

// File: rtl/rx_sync_lane_ctrl_if.sv
// Bundle of the serial input and the four lane outputs of the receive
// controller. The controller side uses the master modport; the serial
// source and lane consumers use the slave modport.
interface rx_sync_lane_ctrl_if;

  logic       data_in;
  logic [7:0] data_out0;
  logic [7:0] data_out1;
  logic [7:0] data_out2;
  logic [7:0] data_out3;
  logic       valid_out0;
  logic       valid_out1;
  logic       valid_out2;
  logic       valid_out3;
  logic       active;
  logic [1:0] sync_state;

  modport master (
    input  data_in,
    output data_out0, data_out1, data_out2, data_out3,
    output valid_out0, valid_out1, valid_out2, valid_out3,
    output active, sync_state
  );

  modport slave (
    output data_in,
    input  data_out0, data_out1, data_out2, data_out3,
    input  valid_out0, valid_out1, valid_out2, valid_out3,
    input  active, sync_state
  );

endinterface : rx_sync_lane_ctrl_if

// File: rtl/rx_deser8.sv
// 8-bit MSB-first deserialiser. Exposes the look-ahead byte (shift register
// with the current input bit appended) and a flag marking the edge that
// samples the last bit of a byte. The bit counter only runs once the FSM
// has left HUNT; realign_i restarts it on a bit-granular comma hit.
module rx_deser8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_i,
  input  logic       hunt_i,
  input  logic       realign_i,
  output logic [7:0] nsr_o,
  output logic       boundary_o
);

  logic [7:0] sr_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;

  // Look-ahead byte and byte-boundary flag.
  always_comb begin
    nsr_o      = {sr_q[6:0], data_i};
    boundary_o = !hunt_i && (bit_cnt_q == 3'd7);
  end

  // Bit position within the byte: cleared on realignment, counts mod 8 outside HUNT.
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    if (realign_i) begin
      bit_cnt_d = 3'd0;
    end else if (!hunt_i) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  // Shift register and bit counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state updates use <= so every register samples pre-edge values.
    if (!rst_n) begin
      sr_q      <= '0;
      bit_cnt_q <= '0;
    end else begin
      sr_q      <= nsr_o;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule : rx_deser8

// File: rtl/rx_sync_lane_ctrl.sv
// Receive-side lane controller: hunts for the comma bit-by-bit, confirms
// byte alignment on COM_COUNT consecutive aligned commas, then distributes
// every non-comma byte round-robin onto four registered lanes with one-cycle
// valid strobes. Once ACTIVE, only reset leaves that state.
module rx_sync_lane_ctrl
  import rx_phy_pkg::*;
#(
  parameter logic [7:0]  COMMA     = COMMA_SYM,
  parameter int unsigned COM_COUNT = 4
) (
  input  logic                        clk_32f,
  input  logic                        reset_L,
  rx_sync_lane_ctrl_if.master         lane_if
);

  localparam logic [3:0] COM_TGT = COM_COUNT[3:0];

  sync_state_e state_q, state_d;
  logic [3:0]  comma_cnt_q, comma_cnt_d;
  logic [1:0]  lane_ptr_q;
  logic [7:0]  data_q [NUM_LANES];
  logic [3:0]  valid_q;

  logic [7:0]  nsr;
  logic        boundary;
  logic        realign;
  logic        lane_wr;
  logic        is_comma;

  rx_deser8 u_deser (
    .clk        (clk_32f),
    .rst_n      (reset_L),
    .data_i     (lane_if.data_in),
    .hunt_i     (state_q == HUNT),
    .realign_i  (realign),
    .nsr_o      (nsr),
    .boundary_o (boundary)
  );

  assign is_comma = (nsr == COMMA);

  // Alignment FSM next state, comma counting and lane-write decision.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    state_d     = state_q;
    comma_cnt_d = comma_cnt_q;
    realign     = 1'b0;
    lane_wr     = 1'b0;
    case (state_q)
      HUNT: begin
        if (is_comma) begin
          realign     = 1'b1;
          comma_cnt_d = 4'd1;
          state_d     = (COM_COUNT == 1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_cnt_q + 4'd1;
            if ((comma_cnt_q + 4'd1) == COM_TGT) begin
              state_d = ACTIVE;
            end
          end else begin
            comma_cnt_d = 4'd0;
            state_d     = HUNT;
          end
        end
      end
      ACTIVE: begin
        lane_wr = boundary && !is_comma;
      end
      default: begin
        state_d     = HUNT;
        comma_cnt_d = 4'd0;
      end
    endcase
  end

  // FSM state and comma counter registers.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= HUNT;
      comma_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      comma_cnt_q <= comma_cnt_d;
    end
  end

  // Lane scheduler: write the byte to the current lane, pulse its strobe, advance.
  always_ff @(posedge clk_32f or negedge reset_L) begin
    // NOTE: lane data registers are reset too, since consumers see zeros after reset.
    if (!reset_L) begin
      lane_ptr_q <= '0;
      valid_q    <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= '0;
      if (lane_wr) begin
        data_q[lane_ptr_q]  <= nsr;
        valid_q[lane_ptr_q] <= 1'b1;
        lane_ptr_q          <= lane_ptr_q + 2'd1;
      end
    end
  end

  assign lane_if.data_out0  = data_q[0];
  assign lane_if.data_out1  = data_q[1];
  assign lane_if.data_out2  = data_q[2];
  assign lane_if.data_out3  = data_q[3];
  assign lane_if.valid_out0 = valid_q[0];
  assign lane_if.valid_out1 = valid_q[1];
  assign lane_if.valid_out2 = valid_q[2];
  assign lane_if.valid_out3 = valid_q[3];
  assign lane_if.active     = (state_q == ACTIVE);
  assign lane_if.sync_state = state_q;

endmodule : rx_sync_lane_ctrl

// File: tb/tb_rx_sync_lane_ctrl.sv
// Self-checking bench for rx_sync_lane_ctrl: directed scenarios plus random
// traffic, every clock compared against a bit-level reference model of the
// link rules (comma hunt, aligned comma count, round-robin lane fill).
module tb_rx_sync_lane_ctrl;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int         COMN  = 4;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;

  rx_sync_lane_ctrl_if bus ();

  rx_sync_lane_ctrl #(.COMMA(COMMA), .COM_COUNT(COMN)) dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .lane_if (bus)
  );

  always #5 clk_32f = ~clk_32f;

  int checks   = 0;
  int failures = 0;
  int strobes_seen = 0;

  // Reference model: mode 0 = hunting, 1 = counting commas, 2 = locked.
  int         m_mode, m_phase, m_commas, m_lane;
  int         m_window;
  logic [7:0] m_data [4];
  logic [3:0] m_valid;

  task automatic ref_reset();
    m_mode = 0; m_phase = 0; m_commas = 0; m_lane = 0; m_window = 0;
    m_valid = '0;
    for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
  endtask

  task automatic ref_step(input logic b);
    int  win;
    bit  at_byte_end;
    win         = ((m_window << 1) | int'(b)) & 255;
    at_byte_end = (m_mode != 0) && (m_phase == 7);
    m_valid     = '0;
    if (m_mode == 0) begin
      if (win == int'(COMMA)) begin
        m_phase  = 0;
        m_commas = 1;
        m_mode   = (COMN == 1) ? 2 : 1;
      end
    end else begin
      if (at_byte_end) begin
        if (m_mode == 1) begin
          if (win == int'(COMMA)) begin
            m_commas++;
            if (m_commas == COMN) m_mode = 2;
          end else begin
            m_commas = 0;
            m_mode   = 0;
          end
        end else if (win != int'(COMMA)) begin
          m_data[m_lane]  = win[7:0];
          m_valid[m_lane] = 1'b1;
          m_lane          = (m_lane + 1) % 4;
        end
      end
      m_phase = (m_phase + 1) % 8;
    end
    m_window = win;
  endtask

  // Drive one bit, let the DUT sample it, then compare every output to the model.
  task automatic send_bit(input logic b, input string tag);
    logic [38:0] act, exp;
    @(negedge clk_32f);
    bus.data_in = b;
    @(posedge clk_32f);
    #1;
    ref_step(b);
    act = {bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0,
           bus.active, bus.sync_state,
           bus.data_out3, bus.data_out2, bus.data_out1, bus.data_out0};
    exp = {m_valid, (m_mode == 2), 2'(m_mode),
           m_data[3], m_data[2], m_data[1], m_data[0]};
    strobes_seen += $countones({bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0});
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @%0t: got {vld,act,st,d3..d0}=%h expected %h", tag, $time, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input string tag);
    for (int i = 7; i >= 0; i--) send_bit(v[i], tag);
  endtask

  task automatic apply_reset();
    @(negedge clk_32f);
    reset_L = 1'b0;
    ref_reset();
    repeat (2) @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    ref_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_32f);
      bus.data_in = i[0];
      @(posedge clk_32f);
      #1;
      checks++;
      if ({bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0, bus.active,
           bus.sync_state, bus.data_out3, bus.data_out2, bus.data_out1, bus.data_out0} !== 39'd0) begin
        failures++;
        $display("FAIL reset_hold: outputs not cleared, sync_state=%0d active=%b expected all zero",
                 bus.sync_state, bus.active);
      end
    end
    @(negedge clk_32f);
    reset_L = 1'b1;
  endtask

  task automatic test_lock();
    logic [7:0] c;
    c = COMMA;
    strobes_seen = 0;
    for (int i = 7; i >= 1; i--) send_bit(c[i], "lock_bits");
    checks++;
    if (bus.sync_state !== 2'd0) begin
      failures++;
      $display("FAIL lock_pre_8th: sync_state=%0d expected 0", bus.sync_state);
    end
    send_bit(c[0], "lock_bits");
    checks++;
    if (bus.sync_state !== 2'd1) begin
      failures++;
      $display("FAIL lock_at_8th: sync_state=%0d expected 1", bus.sync_state);
    end
    send_byte(COMMA, "lock_c2");
    send_byte(COMMA, "lock_c3");
    for (int i = 7; i >= 1; i--) send_bit(c[i], "lock_c4");
    checks++;
    if (bus.active !== 1'b0) begin
      failures++;
      $display("FAIL lock_pre_32nd: active=%b expected 0", bus.active);
    end
    send_bit(c[0], "lock_c4");
    checks++;
    if (bus.active !== 1'b1 || bus.sync_state !== 2'd2) begin
      failures++;
      $display("FAIL lock_at_32nd: active=%b sync_state=%0d expected 1/2", bus.active, bus.sync_state);
    end
    checks++;
    if (strobes_seen != 0) begin
      failures++;
      $display("FAIL lock_no_strobe: strobes=%0d expected 0", strobes_seen);
    end
  endtask

  task automatic test_lane_fill();
    logic [7:0] bytes [4];
    logic [3:0] vl;
    logic [7:0] dv;
    bytes = '{8'hBD, 8'hBD, 8'hBA, 8'hAB};
    for (int k = 0; k < 4; k++) begin
      send_byte(bytes[k], "lane_fill");
      vl = {bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0};
      case (k)
        0: dv = bus.data_out0;
        1: dv = bus.data_out1;
        2: dv = bus.data_out2;
        default: dv = bus.data_out3;
      endcase
      checks++;
      if (vl !== (4'b0001 << k) || dv !== bytes[k]) begin
        failures++;
        $display("FAIL lane_fill_%0d: valid=%b data=%h expected valid=%b data=%h",
                 k, vl, dv, 4'b0001 << k, bytes[k]);
      end
    end
  endtask

  task automatic test_wrap_idle();
    strobes_seen = 0;
    send_byte(COMMA, "idle_comma");
    checks++;
    if (strobes_seen != 0) begin
      failures++;
      $display("FAIL idle_comma: strobes=%0d expected 0", strobes_seen);
    end
    send_byte(8'hFF, "wrap");
    checks++;
    if (bus.valid_out0 !== 1'b1 || bus.data_out0 !== 8'hFF || bus.data_out1 !== 8'hBD ||
        bus.data_out2 !== 8'hBA || bus.data_out3 !== 8'hAB) begin
      failures++;
      $display("FAIL wrap_lane0: v0=%b d0..d3=%h %h %h %h expected 1 ff bd ba ab",
               bus.valid_out0, bus.data_out0, bus.data_out1, bus.data_out2, bus.data_out3);
    end
  endtask

  task automatic test_random_traffic();
    logic [7:0] v;
    for (int k = 0; k < 40; k++) begin
      v = ($urandom_range(0, 3) == 0) ? COMMA : 8'($urandom);
      send_byte(v, "random");
    end
  endtask

  task automatic test_align_failure();
    apply_reset();
    send_byte(COMMA, "alignfail_c1");
    send_byte(COMMA, "alignfail_c2");
    send_byte(8'h55, "alignfail_bad");
    checks++;
    if (bus.sync_state !== 2'd0 || bus.active !== 1'b0) begin
      failures++;
      $display("FAIL alignfail_hunt: sync_state=%0d active=%b expected 0/0", bus.sync_state, bus.active);
    end
    for (int k = 0; k < 4; k++) send_byte(COMMA, "relock");
    checks++;
    if (bus.active !== 1'b1) begin
      failures++;
      $display("FAIL relock: active=%b expected 1", bus.active);
    end
    send_byte(8'($urandom), "relock_data");
    send_byte(8'($urandom), "relock_data");
  endtask

  task automatic test_reset_mid_active();
    logic [7:0] v;
    v = 8'hC3;
    for (int i = 7; i >= 5; i--) send_bit(v[i], "mid_byte");
    #3;
    reset_L = 1'b0;
    ref_reset();
    #1;
    checks++;
    if ({bus.valid_out3, bus.valid_out2, bus.valid_out1, bus.valid_out0, bus.active,
         bus.sync_state, bus.data_out3, bus.data_out2, bus.data_out1, bus.data_out0} !== 39'd0) begin
      failures++;
      $display("FAIL async_clear: sync_state=%0d active=%b d0=%h expected all zero",
               bus.sync_state, bus.active, bus.data_out0);
    end
    repeat (2) @(negedge clk_32f);
    reset_L = 1'b1;
    strobes_seen = 0;
    send_byte(8'h12, "post_reset");
    send_byte(8'h34, "post_reset");
    send_byte(8'h56, "post_reset");
    checks++;
    if (strobes_seen != 0 || bus.active !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_quiet: strobes=%0d active=%b expected 0/0", strobes_seen, bus.active);
    end
    for (int k = 0; k < 4; k++) send_byte(COMMA, "post_reset_lock");
    send_byte(8'h9A, "post_reset_data");
    checks++;
    if (bus.valid_out0 !== 1'b1 || bus.data_out0 !== 8'h9A) begin
      failures++;
      $display("FAIL post_reset_lane0: v0=%b d0=%h expected 1 9a", bus.valid_out0, bus.data_out0);
    end
  endtask

  initial begin
    bus.data_in = 1'b0;
    test_reset();
    test_lock();
    test_lane_fill();
    test_wrap_idle();
    test_random_traffic();
    test_align_failure();
    test_random_traffic();
    test_reset_mid_active();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rx_sync_lane_ctrl

// File: doc/rx_sync_lane_ctrl.md
Name: rx_sync_lane_ctrl

Overview:
Receive-side controller for the serial PHY link. It hunts for comma 0xBC in the MSB-first serial stream on clk_32f, locks byte alignment after COM_COUNT consecutive aligned commas, and then schedules each received non-comma data byte round-robin onto four lane outputs with per-lane valid strobes. It sits between the serial receive pin and the four 8-bit lane consumers.

Parameters:
COMMA, 8'hBC, idle/alignment symbol
COM_COUNT, 4, consecutive aligned commas required to enter ACTIVE (range 1..15)

Ports:
clk_32f  input  1  bit-rate clock
reset_L  input  1  asynchronous active-low reset
data_in  input  1  serial data, MSB of each byte first
data_out0  output  8  lane 0 byte, held until next lane-0 write
data_out1  output  8  lane 1 byte
data_out2  output  8  lane 2 byte
data_out3  output  8  lane 3 byte
valid_out0  output  1  one-cycle strobe: data_out0 updated this cycle
valid_out1  output  1  lane 1 strobe
valid_out2  output  1  lane 2 strobe
valid_out3  output  1  lane 3 strobe
active  output  1  1 while in ACTIVE
sync_state  output  2  current FSM state (debug)

Behaviour:
- One clock, clk_32f; reset_L asynchronous, active-low. While reset_L=0: shift reg=0, bit_cnt=0, comma_cnt=0, lane_ptr=0, state=HUNT, all data_outN=0, all valid_outN=0, active=0.
- Every edge: sr <= nsr, where nsr = {sr[6:0], data_in}.
- Byte boundary = edge where bit_cnt==7 (outside HUNT); bit_cnt increments mod 8 every edge outside HUNT.
- States (sync_state encoding): HUNT=0, ALIGN=1, ACTIVE=2; 3 unused -> HUNT.
- HUNT: compare nsr to COMMA every edge (bit-granular). On match: bit_cnt<=0, comma_cnt<=1; if COM_COUNT==1 go ACTIVE, else ALIGN.
- ALIGN: only boundary edges are evaluated. nsr==COMMA: comma_cnt++; when the increment reaches COM_COUNT go ACTIVE, active<=1 on that same edge. nsr!=COMMA: comma_cnt<=0, go HUNT (a comma match on that same edge does not count). Non-boundary matches are ignored.
- ACTIVE: held until reset; there is no loss-of-sync exit. At a boundary edge:
  - nsr==COMMA: idle symbol; no strobe, lane_ptr unchanged.
  - otherwise: data_out[lane_ptr]<=nsr, valid_out[lane_ptr]<=1, lane_ptr<=lane_ptr+1 mod 4 (3 wraps to 0).
- Strobes: at most one valid_outN high per cycle. Each strobe is high for exactly one cycle, then cleared on the next edge. Non-written lanes hold their data.
- Latency: a data byte appears on its lane, with its strobe, on the same edge that samples its 8th bit (registered outputs, 0 extra cycles).
- Reset mid-byte or mid-ACTIVE discards the partial byte and returns to HUNT with all outputs cleared.

Decomposition:
- Shared package rx_phy_pkg: COMMA constant, state encodings HUNT/ALIGN/ACTIVE, lane count 4.
- Sub-module rx_deser8: shift register plus bit counter, exposing nsr and a boundary flag. The FSM and lane scheduler stay in the top.

Test Plan:
- Reset: reset_L=0 with data_in toggling -> all data_outN=0, valid_outN=0, active=0, sync_state=0.
- Lock: after reset release, send 4×0xBC MSB-first -> sync_state 0->1 at the 8th bit; active=1 on the edge of the 32nd bit; no strobes.
- Lane fill: 4×0xBC then 0xBD, 0xBD, 0xBA, 0xAB -> strobes in order: valid_out0 (data_out0=0xBD), valid_out1 (0xBD), valid_out2 (0xBA), valid_out3 (0xAB), each one cycle at its byte's 8th-bit edge, 8 cycles apart.
- Wrap and idle: continue with 0xBC then 0xFF -> no strobe for 0xBC; 0xFF goes to lane 0 via valid_out0; lanes 1-3 hold their values.
- Align failure: 2×0xBC then 0x55 -> returns to HUNT, comma_cnt=0; a subsequent 4×0xBC re-locks.
- Reset mid-ACTIVE: drop reset_L mid-byte -> immediate clear of all outputs and state; re-lock is required before any strobe.
